// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 neighbourhood generator for a Sobel kernel: two line buffers
// plus a two-column shift register, emitting one registered window per interior pixel.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    output logic       out_eof,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_r, col_s, col_nxt_s;
    logic [RW-1:0] row_r, row_s, row_nxt_s;

    logic [7:0] lb1_r [IMG_WIDTH];
    logic [7:0] lb2_r [IMG_WIDTH];
    logic [7:0] lb1_rd_s, lb2_rd_s;

    // Columns x-1 (c1) and x (c2) of the window; column x-2 only exists in the outputs.
    logic [7:0] top_c1_r, top_c2_r, mid_c1_r, mid_c2_r, bot_c1_r, bot_c2_r;

    logic       emit_s, last_s;
    logic       out_valid_r, out_eof_r;
    logic [7:0] p0_r, p1_r, p2_r, p3_r, p5_r, p6_r, p7_r, p8_r;

    // Effective beat position (sof forces origin), line-buffer reads, emission and counter advance.
    always_comb begin
        col_s     = col_r;
        row_s     = row_r;
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (in_sof) begin
            col_s = '0;
            row_s = '0;
        end else begin
            col_s = col_r;
            row_s = row_r;
        end
        lb1_rd_s = lb1_r[col_s];
        lb2_rd_s = lb2_r[col_s];
        emit_s   = in_valid && (col_s >= CW'(2)) && (row_s >= RW'(2));
        last_s   = (col_s == COL_LAST) && (row_s == ROW_LAST);
        if (col_s == COL_LAST) begin
            col_nxt_s = '0;
            if (row_s == ROW_LAST) begin
                row_nxt_s = '0;
            end else begin
                row_nxt_s = row_s + RW'(1);
            end
        end else begin
            col_nxt_s = col_s + CW'(1);
            row_nxt_s = row_s;
        end
    end

    // Line buffers: unreset storage, read-before-write on the same address each beat.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb2_r[col_s] <= lb1_rd_s;
            lb1_r[col_s] <= in_pixel;
        end
    end

    // Position counters and window shift register advance only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r    <= '0;
            row_r    <= '0;
            top_c1_r <= 8'h00;
            top_c2_r <= 8'h00;
            mid_c1_r <= 8'h00;
            mid_c2_r <= 8'h00;
            bot_c1_r <= 8'h00;
            bot_c2_r <= 8'h00;
        end else if (in_valid) begin
            col_r    <= col_nxt_s;
            row_r    <= row_nxt_s;
            top_c1_r <= top_c2_r;
            top_c2_r <= lb2_rd_s;
            mid_c1_r <= mid_c2_r;
            mid_c2_r <= lb1_rd_s;
            bot_c1_r <= bot_c2_r;
            bot_c2_r <= in_pixel;
        end
    end

    // Registered window outputs: loaded from the post-shift window, held between emissions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_eof_r   <= 1'b0;
            p0_r        <= 8'h00;
            p1_r        <= 8'h00;
            p2_r        <= 8'h00;
            p3_r        <= 8'h00;
            p5_r        <= 8'h00;
            p6_r        <= 8'h00;
            p7_r        <= 8'h00;
            p8_r        <= 8'h00;
        end else begin
            out_valid_r <= emit_s;
            out_eof_r   <= emit_s && last_s;
            if (emit_s) begin
                p0_r <= top_c1_r;
                p1_r <= top_c2_r;
                p2_r <= lb2_rd_s;
                p3_r <= mid_c1_r;
                p5_r <= lb1_rd_s;
                p6_r <= bot_c1_r;
                p7_r <= bot_c2_r;
                p8_r <= in_pixel;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_eof   = out_eof_r;
    assign p0        = p0_r;
    assign p1        = p1_r;
    assign p2        = p2_r;
    assign p3        = p3_r;
    assign p5        = p5_r;
    assign p6        = p6_r;
    assign p7        = p7_r;
    assign p8        = p8_r;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed table-driven bench for sobel_window_gen: a 4x4 instance for frame,
// idle, back-to-back and reset cases, and a 5x5 instance for the sof-abort case.
module tb_sobel_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v4, s4, v5, s5;
    logic [7:0] x4, x5;
    logic       ov4, oe4, ov5, oe5;
    logic [7:0] a0, a1, a2, a3, a5, a6, a7, a8;
    logic [7:0] b0, b1, b2, b3, b5, b6, b7, b8;
    logic [63:0] win4, win5;
    assign win4 = {a0, a1, a2, a3, a5, a6, a7, a8};
    assign win5 = {b0, b1, b2, b3, b5, b6, b7, b8};

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_sof(s4), .in_pixel(x4),
        .out_valid(ov4), .out_eof(oe4),
        .p0(a0), .p1(a1), .p2(a2), .p3(a3), .p5(a5), .p6(a6), .p7(a7), .p8(a8));

    sobel_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_sof(s5), .in_pixel(x5),
        .out_valid(ov5), .out_eof(oe5),
        .p0(b0), .p1(b1), .p2(b2), .p3(b3), .p5(b5), .p6(b6), .p7(b7), .p8(b8));

    typedef struct {
        logic [7:0]  pix;
        logic        sof;
        logic        ev;
        logic        ee;
        logic [63:0] ew;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] img5[5][5];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat4(input logic [7:0] pix, input logic sof, input logic ev,
                         input logic ee, input logic [63:0] ew, output logic got);
        @(negedge clk);
        v4 = 1'b1; s4 = sof; x4 = pix;
        @(posedge clk);
        #1;
        v4 = 1'b0; s4 = 1'b0;
        if (ev) chk("win4", {ov4, oe4, win4}, {1'b1, ee, ew});
        else    chk("novalid4", {ov4, oe4}, 2'b00);
        got = ov4;
    endtask

    task automatic run_frame4(input logic [7:0] off, input logic use_sof, input int max_idle);
        int   n = 0;
        int   k;
        logic g;
        for (int i = 0; i < 16; i++) begin
            beat4(tbl[i].pix + off, use_sof && tbl[i].sof, tbl[i].ev, tbl[i].ee,
                  tbl[i].ew + {8{off}}, g);
            if (g) n++;
            k = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
            for (int j = 0; j < k; j++) begin
                @(posedge clk);
                #1;
                chk("gap4", {ov4, oe4}, 2'b00);
            end
        end
        chk("count4", n, 4);
    endtask

    task automatic beat5(input int x, input int y, input logic sof, output logic got);
        logic        ev;
        logic [63:0] ew;
        @(negedge clk);
        v5 = 1'b1; s5 = sof; x5 = img5[y][x];
        @(posedge clk);
        #1;
        v5 = 1'b0; s5 = 1'b0;
        ev = (x >= 2) && (y >= 2);
        ew = 64'h0;
        if (ev) begin
            ew = {img5[y-2][x-2], img5[y-2][x-1], img5[y-2][x],
                  img5[y-1][x-2], img5[y-1][x],
                  img5[y][x-2],   img5[y][x-1],   img5[y][x]};
            chk("win5", {ov5, oe5, win5}, {1'b1, (x == 4) && (y == 4), ew});
        end else begin
            chk("novalid5", {ov5, oe5}, 2'b00);
        end
        got = ov5;
    endtask

    task automatic run5(input int nbeats, input int exp_windows);
        int   n = 0;
        logic g;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                img5[y][x] = 8'($urandom);
        for (int i = 0; i < nbeats; i++) begin
            beat5(i % 5, i / 5, i == 0, g);
            if (g) n++;
        end
        chk("count5", n, exp_windows);
    endtask

    initial begin
        logic g;
        for (int i = 0; i < 16; i++) begin
            tbl[i].pix = 8'(16 * (i / 4) + (i % 4));
            tbl[i].sof = (i == 0);
            tbl[i].ev  = 1'b0;
            tbl[i].ee  = 1'b0;
            tbl[i].ew  = 64'h0;
        end
        tbl[10].ev = 1'b1; tbl[10].ew = 64'h00_01_02_10_12_20_21_22;
        tbl[11].ev = 1'b1; tbl[11].ew = 64'h01_02_03_11_13_21_22_23;
        tbl[14].ev = 1'b1; tbl[14].ew = 64'h10_11_12_20_22_30_31_32;
        tbl[15].ev = 1'b1; tbl[15].ew = 64'h11_12_13_21_23_31_32_33;
        tbl[15].ee = 1'b1;

        rst_n = 1'b0;
        v4 = 1'b0; s4 = 1'b0; x4 = 8'h00;
        v5 = 1'b0; s5 = 1'b0; x5 = 8'h00;
        #22;
        chk("reset4", {ov4, oe4, win4}, 66'h0);
        chk("reset5", {ov5, oe5, win5}, 66'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // continuous frame, then the same frame with random gaps
        run_frame4(8'h00, 1'b1, 0);
        run_frame4(8'h00, 1'b1, 3);
        // two back-to-back frames with sof only on the first
        run_frame4(8'h00, 1'b1, 0);
        run_frame4(8'h40, 1'b0, 0);
        @(posedge clk);
        #1;
        chk("tail4", {ov4, oe4}, 2'b00);

        // 5x5: abort at (1,3) with a new sof, then a full frame
        run5(16, 3);
        run5(25, 9);

        // async reset mid-frame, after a window has been presented
        for (int i = 0; i < 11; i++)
            beat4(tbl[i].pix + 8'h20, tbl[i].sof, tbl[i].ev, tbl[i].ee,
                  tbl[i].ew + {8{8'h20}}, g);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset4", {ov4, oe4, win4}, 66'h0);
        chk("midreset5", {ov5, oe5, win5}, 66'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame4(8'h08, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
